// File: rtl/nvdla_reset_gen.sv
// Soft/power-on reset sequencer for the NVDLA core reset synchronizer.
// Drives an active-low reset request and waits for synchronized feedback.
module nvdla_reset_gen #(
    parameter int HOLD_W      = 8,
    parameter int MIN_HOLD    = 4,
    parameter int ACK_TIMEOUT = 64
) (
    input  logic              nvdla_clk,
    input  logic              nvdla_rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [HOLD_W-1:0] req_hold,
    output logic              dla_reset_rstn,
    input  logic              synced_rstn,
    output logic              busy,
    output logic              done_pulse,
    output logic              timeout_err
);

    localparam int TW = $clog2(ACK_TIMEOUT);
    localparam logic [TW-1:0] T_LAST = TW'(ACK_TIMEOUT - 1);
    localparam logic [HOLD_W-1:0] MIN_H = HOLD_W'(MIN_HOLD);
    localparam logic [HOLD_W-1:0] ONE_H = HOLD_W'(1);

    typedef enum logic [2:0] {
        S_ASSERT,
        S_HOLD,
        S_RELEASE,
        S_DONE,
        S_IDLE,
        S_ERR
    } state_t;

    state_t            state;
    state_t            nxt;
    logic [TW-1:0]     timer;
    logic [HOLD_W-1:0] hold_len;
    logic [HOLD_W-1:0] hold_cnt;
    logic              accept;

    assign accept = req_valid && req_ready;

    // Ack is tested before the timeout so a same-cycle ack wins.
    always_comb begin
        nxt = state;
        unique case (state)
            S_IDLE: begin
                if (accept) nxt = S_ASSERT;
            end
            S_ASSERT: begin
                if (!synced_rstn)        nxt = S_HOLD;
                else if (timer == T_LAST) nxt = S_ERR;
            end
            S_HOLD: begin
                if (hold_cnt == ONE_H) nxt = S_RELEASE;
            end
            S_RELEASE: begin
                if (synced_rstn)          nxt = S_DONE;
                else if (timer == T_LAST) nxt = S_ERR;
            end
            S_DONE:  nxt = S_IDLE;
            S_ERR:   nxt = S_IDLE;
            default: nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge nvdla_clk) begin
        if (nvdla_rst) begin
            state          <= S_ASSERT;
            hold_len       <= MIN_H;
            hold_cnt       <= MIN_H;
            timer          <= '0;
            dla_reset_rstn <= 1'b0;
            req_ready      <= 1'b0;
            busy           <= 1'b1;
            done_pulse     <= 1'b0;
            timeout_err    <= 1'b0;
        end else begin
            state          <= nxt;
            dla_reset_rstn <= !(nxt == S_ASSERT || nxt == S_HOLD);
            req_ready      <= (nxt == S_IDLE);
            busy           <= (nxt != S_IDLE);
            done_pulse     <= (nxt == S_DONE);

            if (nxt == S_ERR)  timeout_err <= 1'b1;
            else if (accept)   timeout_err <= 1'b0;

            if (accept)
                hold_len <= (req_hold < MIN_H) ? MIN_H : req_hold;

            // Timer restarts on every state change; saturates at the compare.
            if (state != nxt)
                timer <= '0;
            else if ((state == S_ASSERT || state == S_RELEASE) && timer != T_LAST)
                timer <= timer + 1'b1;

            if (nxt == S_HOLD && state != S_HOLD)
                hold_cnt <= hold_len;
            else if (state == S_HOLD)
                hold_cnt <= hold_cnt - ONE_H;
        end
    end

endmodule

// File: tb/tb_nvdla_reset_gen.sv
// Scoreboard bench for nvdla_reset_gen: stimulus queues expected sequence
// outcomes, a negedge monitor pops them on done_pulse / timeout_err.
module tb_nvdla_reset_gen;

    logic       nvdla_clk = 1'b0;
    logic       nvdla_rst;
    logic       req_valid;
    logic       req_ready;
    logic [7:0] req_hold;
    logic       dla_reset_rstn;
    logic       synced_rstn;
    logic       busy;
    logic       done_pulse;
    logic       timeout_err;

    logic s1 = 1'b1;
    logic s2 = 1'b1;
    logic force_en = 1'b0;
    logic force_val = 1'b0;

    typedef struct {
        bit is_err;
        int low;
    } exp_t;

    exp_t q[$];
    int   n_pass = 0;
    int   n_total = 0;
    int   lowcnt = 0;
    int   last_low = 0;
    logic prev_terr = 1'b0;

    nvdla_reset_gen #(
        .HOLD_W(8),
        .MIN_HOLD(4),
        .ACK_TIMEOUT(64)
    ) dut (
        .nvdla_clk(nvdla_clk),
        .nvdla_rst(nvdla_rst),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_hold(req_hold),
        .dla_reset_rstn(dla_reset_rstn),
        .synced_rstn(synced_rstn),
        .busy(busy),
        .done_pulse(done_pulse),
        .timeout_err(timeout_err)
    );

    always #5 nvdla_clk = ~nvdla_clk;

    // Two-flop synchronizer model, overridable for ack-timing cases.
    always @(posedge nvdla_clk) begin
        s1 <= dla_reset_rstn;
        s2 <= s1;
    end
    assign synced_rstn = force_en ? force_val : s2;

    task automatic check(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic tick();
        @(posedge nvdla_clk);
        #1;
    endtask

    task automatic push(input bit is_err, input int low);
        exp_t e;
        e.is_err = is_err;
        e.low    = low;
        q.push_back(e);
    endtask

    task automatic wait_idle(input string name);
        for (int i = 0; i < 300; i++) begin
            if (req_ready) break;
            tick();
        end
        check(name, int'(req_ready), 1);
    endtask

    task automatic wait_release(input string name);
        for (int i = 0; i < 300; i++) begin
            tick();
            if (dla_reset_rstn) break;
        end
        check(name, int'(dla_reset_rstn), 1);
    endtask

    task automatic do_req(input int h);
        req_hold  = 8'(h);
        req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        check("ready_drop", int'(req_ready), 0);
        check("busy_rise", int'(busy), 1);
        check("rstn_low", int'(dla_reset_rstn), 0);
        check("err_cleared", int'(timeout_err), 0);
    endtask

    task automatic check_rst_state();
        check("rst_rstn", int'(dla_reset_rstn), 0);
        check("rst_ready", int'(req_ready), 0);
        check("rst_busy", int'(busy), 1);
        check("rst_done", int'(done_pulse), 0);
        check("rst_err", int'(timeout_err), 0);
    endtask

    // Monitor: tracks the latest low run and scores each sequence outcome.
    always @(negedge nvdla_clk) begin
        if (nvdla_rst) begin
            lowcnt = 0;
        end else if (!dla_reset_rstn) begin
            lowcnt++;
        end else if (lowcnt != 0) begin
            last_low = lowcnt;
            lowcnt   = 0;
        end
        if (!nvdla_rst && (done_pulse || (timeout_err && !prev_terr))) begin
            check("event_expected", int'(q.size() != 0), 1);
            if (q.size() != 0) begin
                exp_t e;
                e = q.pop_front();
                check("event_is_err", int'(!done_pulse), int'(e.is_err));
                check("low_cycles", last_low, e.low);
                if (done_pulse)
                    check("done_no_err", int'(timeout_err), 0);
            end
        end
        prev_terr = timeout_err;
    end

    initial begin
        int n;
        nvdla_rst = 1'b1;
        req_valid = 1'b0;
        req_hold  = 8'd0;

        // Power-on: 1 ASSERT cycle after release + 4 HOLD cycles.
        tick();
        check_rst_state();
        tick();
        tick();
        push(1'b0, 5);
        nvdla_rst = 1'b0;
        wait_idle("por_idle");
        check("por_err", int'(timeout_err), 0);

        // hold 10: 3 ASSERT cycles (2-flop feedback) + 10.
        push(1'b0, 13);
        do_req(10);
        wait_idle("h10_idle");

        push(1'b0, 7);
        do_req(0);
        wait_idle("h0_idle");
        push(1'b0, 7);
        do_req(3);
        wait_idle("h3_idle");

        // Stuck-high feedback: ERR after 64 ASSERT cycles.
        force_en  = 1'b1;
        force_val = 1'b1;
        push(1'b1, 64);
        do_req(8);
        n = 0;
        for (int i = 0; i < 200; i++) begin
            tick();
            n++;
            if (timeout_err) break;
        end
        check("err_latency", n, 64);
        check("err_rstn_high", int'(dla_reset_rstn), 1);
        check("err_no_done", int'(done_pulse), 0);
        repeat (4) tick();
        check("err_sticky", int'(timeout_err), 1);
        check("err_idle_ready", int'(req_ready), 1);
        force_en = 1'b0;
        repeat (3) tick();
        push(1'b0, 11);
        do_req(8);
        wait_idle("clr_idle");

        // Release ack present in the 64th RELEASE cycle: still in time.
        force_en  = 1'b1;
        force_val = 1'b0;
        push(1'b0, 6);
        do_req(5);
        wait_release("ack63_rel");
        repeat (63) tick();
        force_val = 1'b1;
        wait_idle("ack63_idle");
        check("ack63_no_err", int'(timeout_err), 0);

        // Ack one cycle later: timeout wins.
        force_val = 1'b0;
        push(1'b1, 6);
        do_req(5);
        wait_release("ack64_rel");
        repeat (64) tick();
        force_val = 1'b1;
        check("ack64_err", int'(timeout_err), 1);
        wait_idle("ack64_idle");
        force_en = 1'b0;
        repeat (3) tick();

        // req_valid held: second run only after IDLE, hold sampled then.
        push(1'b0, 9);
        push(1'b0, 23);
        req_hold  = 8'd6;
        req_valid = 1'b1;
        tick();
        req_hold = 8'd20;
        check("held_ready_drop", int'(req_ready), 0);
        n = 0;
        for (int i = 0; i < 300; i++) begin
            tick();
            if (done_pulse) n++;
            if (n == 2) break;
        end
        req_valid = 1'b0;
        check("held_two_runs", n, 2);
        wait_idle("held_idle");

        // Reset in HOLD aborts; power-on sequence restarts.
        do_req(10);
        repeat (6) tick();
        nvdla_rst = 1'b1;
        tick();
        check_rst_state();
        tick();
        push(1'b0, 5);
        nvdla_rst = 1'b0;
        wait_idle("abort_idle");

        repeat (5) tick();
        check("queue_drained", q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
